dec_scoreboard: RTL and testbench

DEC_SCOREBOARD -- requirements
Module: dec_scoreboard

---
 rtl/dec_scoreboard.sv | 145 ++++++++++++++
 tb/tb_dec_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_scoreboard.sv
// dec_scoreboard: decode-stage register scoreboard with hazard detection.
//
// Tracks one pending-write bit per architectural register (16 registers, r0
// included). An instruction in decode issues when none of its source
// registers is pending and its destination (if any) is not already pending
// (WAW). Write-back clears a pending bit; an issue that sets the same bit on
// the same edge takes priority. A saturating counter of consecutive stall
// cycles raises a sticky hang flag once it reaches HANG_LIMIT.
//
// Optional feature (macro SB_WB_BYPASS_EN):
//   defined   - a register being written back this cycle counts as not busy
//               for this cycle's hazard check (register-file write-through).
//   undefined - the write-back clear is seen only from the next cycle.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   dec_valid            decode stage holds an instruction
//   instr_type           00 R-type, 01 branch, 10 I-type, 11 no-op
//   rs1, rs2, rd         source / destination register addresses
//   flush                kill the instruction currently in decode
//   wb_wen, wb_addr      register file write-back this cycle
//   issue, stall         combinational decode outcome
//   busy                 registered pending-write bit per register
//   hang                 registered sticky stall-timeout flag
//   issue_cnt            registered count of issued instructions (wraps)
module dec_scoreboard #(
  parameter int unsigned HANG_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [1:0]  instr_type,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  rd,
  input  logic        flush,
  input  logic        wb_wen,
  input  logic [3:0]  wb_addr,
  output logic        issue,
  output logic        stall,
  output logic [15:0] busy,
  output logic        hang,
  output logic [15:0] issue_cnt
);

  typedef enum logic [1:0] {
    TypeR   = 2'b00,
    TypeBr  = 2'b01,
    TypeI   = 2'b10,
    TypeNop = 2'b11
  } instr_type_e;

  logic [15:0] busy_q, busy_d;
  logic [15:0] busy_eff;
  logic        hang_q, hang_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;

  logic reads_rs1, reads_rs2, writes_rd;
  logic hazard;

  // Operand usage decode.
  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    unique case (instr_type)
      TypeR: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        writes_rd = 1'b1;
      end
      TypeBr: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      TypeI: begin
        reads_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      TypeNop: begin
      end
    endcase
  end

  // Busy view used for the hazard check this cycle.
  always_comb begin
    busy_eff = busy_q;
`ifdef SB_WB_BYPASS_EN
    if (wb_wen) begin
      busy_eff[wb_addr] = 1'b0;
    end
`endif
  end

  always_comb begin
    hazard = dec_valid & ((reads_rs1 & busy_eff[rs1]) |
                          (reads_rs2 & busy_eff[rs2]) |
                          (writes_rd & busy_eff[rd]));
    stall  = hazard & ~flush;
    issue  = dec_valid & ~hazard & ~flush;
  end

  always_comb begin
    busy_d = busy_q;
    // Clear first so a same-edge set on the same register wins.
    if (wb_wen) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (issue && writes_rd) begin
      busy_d[rd] = 1'b1;
    end

    issue_cnt_d = issue_cnt_q + {15'd0, issue};

    if (!stall) begin
      stall_cnt_d = 8'd0;
    end else if (stall_cnt_q == 8'hff) begin
      stall_cnt_d = 8'hff;
    end else begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end

    hang_d = hang_q | (stall & ({24'd0, stall_cnt_d} >= HANG_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 16'd0;
      hang_q      <= 1'b0;
      issue_cnt_q <= 16'd0;
      stall_cnt_q <= 8'd0;
    end else begin
      busy_q      <= busy_d;
      hang_q      <= hang_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign hang      = hang_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_dec_scoreboard.sv
// Scoreboard bench for dec_scoreboard: a driver issues per-cycle stimulus and
// pushes the reference model's expected outputs into a queue; a monitor on
// the falling clock edge pops and compares against the DUT.
module tb_dec_scoreboard;

  localparam int unsigned HangLimit = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0;
  logic [1:0]  instr_type = 2'b11;
  logic [3:0]  rs1 = 4'd0;
  logic [3:0]  rs2 = 4'd0;
  logic [3:0]  rd = 4'd0;
  logic        flush = 1'b0;
  logic        wb_wen = 1'b0;
  logic [3:0]  wb_addr = 4'd0;
  logic        issue;
  logic        stall;
  logic [15:0] busy;
  logic        hang;
  logic [15:0] issue_cnt;

  dec_scoreboard #(
    .HANG_LIMIT(HangLimit)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_valid  (dec_valid),
    .instr_type (instr_type),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .flush      (flush),
    .wb_wen     (wb_wen),
    .wb_addr    (wb_addr),
    .issue      (issue),
    .stall      (stall),
    .busy       (busy),
    .hang       (hang),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        issue;
    logic        stall;
    logic [15:0] busy;
    logic        hang;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk = 1'b1;

  // Reference model state: set of registers with an outstanding write,
  // length of the current stall run, sticky hang, and issue count.
  bit          pend[16];
  bit          m_hang;
  int unsigned m_run;
  int unsigned m_cnt;

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
    m_hang = 1'b0;
    m_run  = 0;
    m_cnt  = 0;
  endfunction

  function automatic bit pending(input logic [3:0] r);
    bit p;
    p = pend[r];
`ifdef SB_WB_BYPASS_EN
    if (wb_wen && wb_addr == r) p = 1'b0;
`endif
    return p;
  endfunction

  function automatic bit writes_rd(input logic [1:0] t);
    return (t == 2'b00) || (t == 2'b10);
  endfunction

  function automatic bit m_hazard();
    bit h;
    if (!dec_valid) return 1'b0;
    case (instr_type)
      2'b00, 2'b01: h = pending(rs1) || pending(rs2);
      2'b10:        h = pending(rs1);
      default:      h = 1'b0;
    endcase
    if (writes_rd(instr_type) && pending(rd)) h = 1'b1;
    return h;
  endfunction

  // One clock cycle: predict, queue the prediction, advance the model.
  task automatic tick();
    exp_t e;
    bit   hz;
    if (!rst_n) model_clear();
    hz      = m_hazard();
    e.issue = dec_valid && !hz && !flush;
    e.stall = hz && !flush;
    for (int i = 0; i < 16; i++) e.busy[i] = pend[i];
    e.hang  = m_hang;
    e.cnt   = 16'(m_cnt);
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (wb_wen) pend[wb_addr] = 1'b0;
      if (e.issue) begin
        m_cnt = (m_cnt + 1) % 65536;
        if (writes_rd(instr_type)) pend[rd] = 1'b1;
      end
      m_run = e.stall ? m_run + 1 : 0;
      if (HangLimit <= 255 && m_run >= HangLimit) m_hang = 1'b1;
    end
    #1;
  endtask

  task automatic drv(input bit v, input logic [1:0] t, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] d, input bit fl,
                     input bit we, input logic [3:0] wa);
    dec_valid  = v;
    instr_type = t;
    rs1        = a;
    rs2        = b;
    rd         = d;
    flush      = fl;
    wb_wen     = we;
    wb_addr    = wa;
    tick();
  endtask

  task automatic idle(input bit we, input logic [3:0] wa);
    drv(1'b0, 2'b11, 4'd0, 4'd0, 4'd0, 1'b0, we, wa);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("issue", {15'd0, issue}, {15'd0, e.issue});
      cmp("stall", {15'd0, stall}, {15'd0, e.stall});
      cmp("busy", busy, e.busy);
      cmp("hang", {15'd0, hang}, {15'd0, e.hang});
      cmp("issue_cnt", issue_cnt, e.cnt);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    // Reset: outputs follow hazard rules with busy clear, nothing counts.
    drv(1, 2'b00, 4'd1, 4'd2, 4'd3, 0, 0, 4'd0);
    rst_n = 1'b1;

    // R-type rd=3 issues, busy=0x0008 afterwards, issue_cnt=1.
    drv(1, 2'b00, 4'd1, 4'd2, 4'd3, 0, 0, 4'd0);
    idle(0, 4'd0);

    // I-type rs1=3 rd=5 while r3 is written back.
    drv(1, 2'b10, 4'd3, 4'd0, 4'd5, 0, 1, 4'd3);
    drv(1, 2'b10, 4'd3, 4'd0, 4'd5, 0, 0, 4'd0);
    idle(1, 4'd5);
    idle(0, 4'd0);

    // WAW on r7 until its write-back retires.
    drv(1, 2'b00, 4'd1, 4'd2, 4'd7, 0, 0, 4'd0);
    repeat (3) drv(1, 2'b00, 4'd1, 4'd2, 4'd7, 0, 0, 4'd0);
    drv(1, 2'b00, 4'd1, 4'd2, 4'd7, 0, 1, 4'd7);
    drv(1, 2'b00, 4'd1, 4'd2, 4'd7, 0, 0, 4'd0);

    // Flush of a hazard-free instruction, and r0 as an ordinary register.
    drv(1, 2'b00, 4'd1, 4'd2, 4'd9, 1, 0, 4'd0);
    drv(1, 2'b10, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0);
    drv(1, 2'b01, 4'd0, 4'd4, 4'd0, 0, 0, 4'd0);
    drv(1, 2'b00, 4'd7, 4'd0, 4'd0, 1, 1, 4'd0);
    idle(0, 4'd0);

    // Asynchronous reset mid-operation, then stale write-backs.
    drv(1, 2'b00, 4'd1, 4'd2, 4'd11, 0, 0, 4'd0);
    rst_n = 1'b0;
    drv(1, 2'b10, 4'd11, 4'd0, 4'd12, 0, 0, 4'd0);
    rst_n = 1'b1;
    idle(1, 4'd11);
    idle(1, 4'd7);
    idle(0, 4'd0);

    // Randomised traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      drv(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
          4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
          4'($urandom_range(0, 5)));
    end
    rst_n = 1'b1;

    // Stall timeout: 300 stalled cycles, then clear the hazard.
    rst_n = 1'b0;
    idle(0, 4'd0);
    rst_n = 1'b1;
    drv(1, 2'b00, 4'd1, 4'd2, 4'd7, 0, 0, 4'd0);
    repeat (300) drv(1, 2'b00, 4'd7, 4'd7, 4'd8, 0, 0, 4'd0);
    idle(1, 4'd7);
    drv(1, 2'b00, 4'd7, 4'd7, 4'd8, 0, 0, 4'd0);
    idle(0, 4'd0);
    rst_n = 1'b0;
    idle(0, 4'd0);
    rst_n = 1'b1;
    idle(0, 4'd0);

    // issue_cnt wrap: only the last few cycles are checked.
    chk = 1'b0;
    for (int i = 0; i < 65533; i++) drv(1, 2'b11, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0);
    chk = 1'b1;
    repeat (4) drv(1, 2'b11, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0);
    idle(0, 4'd0);
    idle(0, 4'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
